cp0_timer_intc: RTL and testbench
=================================

// Module: cp0_timer_intc
// PURPOSE
//  Parametrised timer and interrupt-pending unit for the CP0 block. Provides a prescaled free-running Count register.
//  Provides N_TIMERS Compare channels, each with its own sticky match flag.
//  Combines timer, hardware and software interrupt sources into one pending vector, masked by IM/IE/EXL.
//  Produces the interrupt request plus a priority-encoded source id for the exception stage.
// PARAMETERS
//  CNT_W     32  width of Count and each Compare register (8..32)
//  PRESCALE  2   clk cycles per Count increment (1..16)
//  N_TIMERS  2   number of Compare channels (1..4)
//  N_HWINT   6   external hardware interrupt lines (1..8)
//  N_SWINT   2   software interrupt bits (0..2)
//  Local: P = N_SWINT+N_HWINT+N_TIMERS (P<=16); pend/IM bit order {timer[N_TIMERS-1:0], hw[N_HWINT-1:0], sw[N_SWINT-1:0]}
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous reset, active-high
//  ext_int    in   N_HWINT  external interrupt levels, asynchronous to software
//  wen        in   1      register write strobe
//  addr       in   8      register address: 00 COUNT, 01 CTRL, 02 PEND, 10+i COMPARE[i]
//  wdata      in   32     write data
//  rdata      out  32     read data (combinational on addr, zero-extended, 0 for unmapped)
//  ex_valid   in   1      exception or interrupt taken this cycle
//  ex_eret    in   1      qualifies ex_valid: eret
//  int_req    out  1      unmasked interrupt pending and IE=1 and EXL=0
//  int_id     out  4      index of lowest-numbered set bit of (pend & IM); 0 when none
//  timer_hit  out  N_TIMERS  sticky per-channel match flags (copy of pend timer field)
// BEHAVIOUR
//  Reset: count=0, prescale cnt=0, compare[i]=all-ones, IM=0, IE=0, EXL=0, pend=0 -> int_req=0, int_id=0, timer_hit=0.
//  Prescaler: counts 0..PRESCALE-1 and wraps. Count increments on the wrap cycle (every cycle when PRESCALE=1).
//   Count wraps all-ones -> 0 with no flag.
//  COUNT write: count<=wdata[CNT_W-1:0] and prescaler<=0; the write wins over the increment in the same cycle.
//  COMPARE[i] write (i<N_TIMERS): compare[i]<=wdata and timer pend[i]<=0. Writes to i>=N_TIMERS are ignored.
//  Match: each cycle, if the registered count==compare[i], set pend timer[i] (sticky, 1-cycle latency).
//   A COMPARE[i] write in the same cycle clears and wins over the match.
//   A match is re-detected every cycle the equality holds (count stalled by prescaler) unless compare is rewritten.
//  ext_int: two-flop synchroniser, then level-copied into pend hw field (3 cycles input->pend). Not sticky. Not writable.
//  PEND write: only the sw field is written (wdata[N_SWINT-1:0]); hw and timer fields are unaffected.
//  CTRL layout {IM[P-1:0] at [P+1:2], EXL at [1], IE at [0]}. CTRL write updates IM, EXL and IE.
//  EXL priority: reset > ex_valid (EXL<=!ex_eret) > CTRL write.
//  int_req/int_id: combinational from registered pend, IM, IE, EXL (no input->output combinational path).
//   int_id is the lowest set index of pend&IM; it is valid even when IE=0.
//  Simultaneous COUNT write and match: compare uses the pre-write count value this cycle.
//  Reset mid-operation: all state returns to reset values next edge. The synchroniser is also cleared.
//  rdata: COUNT/COMPARE zero-extended from CNT_W; PEND zero-extended from P; CTRL as the layout above.
// TESTING
//  1 Reset, PRESCALE=2: read COUNT after 10 cycles -> 5; int_req=0, int_id=0.
//  2 COMPARE0=8, COUNT=0, IM=timer0 bit, IE=1 -> pend timer0 sets on the cycle after count==8;
//    int_req=1, int_id=N_SWINT+N_HWINT; COMPARE0 write -> int_req=0 next cycle.
//  3 ext_int[2] pulsed high 1 cycle -> pend hw2 high 3 cycles later for 1 cycle; with IM set, int_req follows the same window.
//  4 Pending enabled int, ex_valid=1/ex_eret=0 -> EXL=1, int_req=0.
//    ex_valid=1/ex_eret=1 -> EXL=0, int_req=1; a CTRL write the same cycle does not override EXL.
//  5 COUNT=all-ones write then tick -> COUNT=0. COMPARE write and match in the same cycle -> pend stays 0.
//  6 PEND write 0x3 with hw pending -> sw bits=11, hw bits unchanged; two sources enabled -> int_id = lower index.

Source files
------------

// File: rtl/cp0_timer_intc.sv
// CP0 timer and interrupt-pending unit: prescaled Count, N Compare channels with
// sticky match flags, and a masked pending vector feeding a priority-encoded request.
module cp0_timer_intc #(
   parameter int CNT_W    = 32,
   parameter int PRESCALE = 2,
   parameter int N_TIMERS = 2,
   parameter int N_HWINT  = 6,
   parameter int N_SWINT  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_HWINT-1:0]  ext_int,
   input  logic                wen,
   input  logic [7:0]          addr,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata,
   input  logic                ex_valid,
   input  logic                ex_eret,
   output logic                int_req,
   output logic [3:0]          int_id,
   output logic [N_TIMERS-1:0] timer_hit
);

   localparam int P     = N_SWINT + N_HWINT + N_TIMERS;
   localparam int HW_LO = N_SWINT;
   localparam int TM_LO = N_SWINT + N_HWINT;
   localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0]     ps_cnt;
   logic                tick;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    compare [N_TIMERS];
   logic [N_HWINT-1:0]  sync_p0;
   logic [N_HWINT-1:0]  sync_p1;
   logic [P-1:0]        pend;
   logic [P-1:0]        im;
   logic                ie;
   logic                exl;
   logic [P-1:0]        masked;

   logic                count_wr;
   logic                ctrl_wr;
   logic                pend_wr;
   logic [N_TIMERS-1:0] cmp_wr;

   assign count_wr = wen && (addr == 8'h00);
   assign ctrl_wr  = wen && (addr == 8'h01);
   assign pend_wr  = wen && (addr == 8'h02);

   always_comb begin
      cmp_wr = '0;
      for (int i = 0; i < N_TIMERS; i++) begin
         cmp_wr[i] = wen && (addr == (8'h10 + 8'(i)));
      end
   end

   assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

   // Prescaler and Count; a COUNT write also restarts the prescale phase
   always_ff @(posedge clk) begin
      if (reset) begin
         ps_cnt <= '0;
         count  <= '0;
      end else if (count_wr) begin
         ps_cnt <= '0;
         count  <= wdata[CNT_W-1:0];
      end else begin
         ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
         if (tick) begin
            count <= count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_TIMERS; i++) begin
            compare[i] <= '1;
         end
      end else begin
         for (int i = 0; i < N_TIMERS; i++) begin
            if (cmp_wr[i]) begin
               compare[i] <= wdata[CNT_W-1:0];
            end
         end
      end
   end

   // Two-flop synchroniser for the asynchronous hardware lines
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= ext_int;
         sync_p1 <= sync_p0;
      end
   end

   // Pending vector: sw written by software, hw level-copied, timer sticky until
   // its Compare is rewritten (the rewrite wins over a same-cycle match)
   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= '0;
      end else begin
         for (int s = 0; s < N_SWINT; s++) begin
            if (pend_wr) begin
               pend[s] <= wdata[s];
            end
         end
         for (int h = 0; h < N_HWINT; h++) begin
            pend[HW_LO + h] <= sync_p1[h];
         end
         for (int t = 0; t < N_TIMERS; t++) begin
            if (cmp_wr[t]) begin
               pend[TM_LO + t] <= 1'b0;
            end else if (count == compare[t]) begin
               pend[TM_LO + t] <= 1'b1;
            end
         end
      end
   end

   // Exception entry/return owns EXL over a same-cycle CTRL write
   always_ff @(posedge clk) begin
      if (reset) begin
         im  <= '0;
         ie  <= 1'b0;
         exl <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            im <= wdata[P+1:2];
            ie <= wdata[0];
         end
         if (ex_valid) begin
            exl <= !ex_eret;
         end else if (ctrl_wr) begin
            exl <= wdata[1];
         end
      end
   end

   assign masked    = pend & im;
   assign int_req   = (|masked) && ie && !exl;
   assign timer_hit = pend[TM_LO +: N_TIMERS];

   always_comb begin
      int_id = 4'd0;
      for (int i = P - 1; i >= 0; i--) begin
         if (masked[i]) begin
            int_id = 4'(i);
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         8'h00: rdata[CNT_W-1:0] = count;
         8'h01: rdata[P+1:0]     = {im, exl, ie};
         8'h02: rdata[P-1:0]     = pend;
         default: begin
            for (int i = 0; i < N_TIMERS; i++) begin
               if (addr == (8'h10 + 8'(i))) begin
                  rdata[CNT_W-1:0] = compare[i];
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_cp0_timer_intc.sv
// Directed bench for cp0_timer_intc at default parameters (P=10: sw[1:0], hw[7:2], timer[9:8]).
module tb_cp0_timer_intc;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  ext_int;
   logic        wen;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ex_valid;
   logic        ex_eret;
   logic        int_req;
   logic [3:0]  int_id;
   logic [1:0]  timer_hit;

   int checks = 0;
   int errors = 0;
   logic [31:0] r;

   cp0_timer_intc dut (
      .clk       (clk),
      .reset     (reset),
      .ext_int   (ext_int),
      .wen       (wen),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .ex_valid  (ex_valid),
      .ex_eret   (ex_eret),
      .int_req   (int_req),
      .int_id    (int_id),
      .timer_hit (timer_hit)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      wen = 1'b1; addr = a; wdata = d;
      cyc(1);
      wen = 1'b0; wdata = '0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] v);
      addr = a;
      #1;
      v = rdata;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; ext_int = '0; wen = 1'b0; addr = '0; wdata = '0;
      ex_valid = 1'b0; ex_eret = 1'b0;
      cyc(3);

      // reset state
      rd(8'h00, r); check("rst_count", r, 32'h0);
      rd(8'h01, r); check("rst_ctrl", r, 32'h0);
      rd(8'h02, r); check("rst_pend", r, 32'h0);
      rd(8'h10, r); check("rst_cmp0", r, 32'hFFFF_FFFF);
      check("rst_int_req", {31'b0, int_req}, 32'h0);
      check("rst_int_id", {28'b0, int_id}, 32'h0);
      check("rst_timer_hit", {30'b0, timer_hit}, 32'h0);

      // 1: prescale 2 -> count 5 after 10 cycles
      reset = 1'b0;
      cyc(10);
      rd(8'h00, r); check("count_after_10", r, 32'd5);
      rd(8'h12, r); check("unmapped_cmp2", r, 32'h0);
      rd(8'h05, r); check("unmapped_05", r, 32'h0);

      // 2: timer0 match at count 8
      wr(8'h10, 32'd8);
      wr(8'h00, 32'd0);
      wr(8'h01, 32'h0000_0401);
      cyc(15);
      rd(8'h00, r); check("count_at_8", r, 32'd8);
      check("hit_before", {30'b0, timer_hit}, 32'h0);
      cyc(1);
      check("hit_after", {30'b0, timer_hit}, 32'h1);
      check("t0_int_req", {31'b0, int_req}, 32'h1);
      check("t0_int_id", {28'b0, int_id}, 32'd8);
      // rewrite while count still equals 8: clear wins over match
      wr(8'h10, 32'h0000_1000);
      check("cmpwr_int_req", {31'b0, int_req}, 32'h0);
      check("cmpwr_hit", {30'b0, timer_hit}, 32'h0);
      cyc(1);
      check("cmpwr_hit_later", {30'b0, timer_hit}, 32'h0);

      // 3: ext_int[2] pulse, hw2 is pend bit 4 -> CTRL bit 6
      wr(8'h01, 32'h0000_0041);
      ext_int = 6'b000100;
      cyc(1);
      ext_int = '0;
      check("hw_edge1", {31'b0, int_req}, 32'h0);
      cyc(1);
      check("hw_edge2", {31'b0, int_req}, 32'h0);
      cyc(1);
      check("hw_edge3_req", {31'b0, int_req}, 32'h1);
      check("hw_edge3_id", {28'b0, int_id}, 32'd4);
      rd(8'h02, r); check("hw_edge3_pend", r, 32'h0000_0010);
      cyc(1);
      check("hw_edge4_req", {31'b0, int_req}, 32'h0);
      rd(8'h02, r); check("hw_edge4_pend", r, 32'h0);

      // 4: EXL via exception entry and eret
      wr(8'h02, 32'h1);
      wr(8'h01, 32'h0000_0005);
      check("sw0_req", {31'b0, int_req}, 32'h1);
      ex_valid = 1'b1; ex_eret = 1'b0;
      cyc(1);
      ex_valid = 1'b0;
      check("exl_req", {31'b0, int_req}, 32'h0);
      rd(8'h01, r); check("exl_ctrl", r, 32'h0000_0007);
      ex_valid = 1'b1; ex_eret = 1'b1;
      wr(8'h01, 32'h0000_0007);
      ex_valid = 1'b0; ex_eret = 1'b0;
      rd(8'h01, r); check("eret_ctrl", r, 32'h0000_0005);
      check("eret_req", {31'b0, int_req}, 32'h1);

      // 5: count wrap; compare1 reset value all-ones matches on the way
      wr(8'h00, 32'hFFFF_FFFF);
      cyc(1);
      rd(8'h00, r); check("count_ones", r, 32'hFFFF_FFFF);
      check("cmp1_hit", {30'b0, timer_hit}, 32'h2);
      cyc(1);
      rd(8'h00, r); check("count_wrap", r, 32'h0);
      wr(8'h11, 32'hFFFF_FFF0);
      check("cmp1_cleared", {30'b0, timer_hit}, 32'h0);

      // 6: PEND write touches only sw bits; lowest enabled index wins
      ext_int = 6'b000100;
      cyc(3);
      wr(8'h02, 32'h3);
      rd(8'h02, r); check("pend_sw_hw", r, 32'h0000_0013);
      wr(8'h01, 32'h0000_0049);
      check("prio_req", {31'b0, int_req}, 32'h1);
      check("prio_id_sw1", {28'b0, int_id}, 32'd1);
      wr(8'h02, 32'h0);
      rd(8'h02, r); check("pend_hw_only", r, 32'h0000_0010);
      check("prio_id_hw2", {28'b0, int_id}, 32'd4);

      // mid-operation reset clears synchroniser and all state
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      ext_int = '0;
      rd(8'h02, r); check("rst2_pend", r, 32'h0);
      cyc(1);
      rd(8'h02, r); check("rst2_pend_sync", r, 32'h0);
      rd(8'h11, r); check("rst2_cmp1", r, 32'hFFFF_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
